multi_channel_dma_read: RTL and testbench

MULTI_CHANNEL_DMA_READ -- requirements
Module: multi_channel_dma_read

---
 rtl/multi_channel_dma_read.sv | 271 +++++++++++++++++++++++++++
 tb/tb_multi_channel_dma_read.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_dma_read.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multi_channel_dma_read                                        |
// | Purpose  : Multi-channel cache-line read DMA. Each channel walks a line   |
// |            range and requests lines through one shared read port. A     |
// |            round-robin arbiter picks the channel. Responses come back   |
// |            in issue order and are steered by an in-order tag FIFO.      |
// | Option   : MULTI_CHANNEL_DMA_READ_BURST_EN -- when defined, requests    |
// |            carry 1/2/4-line bursts sized from address alignment. When  |
// |            undefined, every request is a single line.                   |
// | Ports    : clk, resetn          clock, synchronous active-low reset      |
// |            ch_start/addr/lines  per-channel transfer start + parameters  |
// |            ch_almostfull        per-channel consumer back-pressure       |
// |            ch_busy/done/rvalid  per-channel status and read-data valid   |
// |            ch_rdata             shared read data, qualified by rvalid    |
// |            tx_re/raddr/rlength  request port, tx_ralmostfull = stall     |
// |            rx_rvalid/rdata      response port                            |
// |            err                  sticky: response arrived with no tag     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module multi_channel_dma_read #(
  parameter int NUM_CHANNELS         = 2,
  parameter int DATA_WIDTH           = 512,
  parameter int ADDRESS_WIDTH        = 42,
  parameter int LOG2_MAX_OUTSTANDING = 6,   // must be >= 2 so a 4-line burst fits
  parameter int LOG2_TAG_DEPTH       = 6
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [NUM_CHANNELS-1:0]             ch_start,
  input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] ch_addr,
  input  logic [NUM_CHANNELS*16-1:0]          ch_lines,
  input  logic [NUM_CHANNELS-1:0]             ch_almostfull,
  output logic [NUM_CHANNELS-1:0]             ch_busy,
  output logic [NUM_CHANNELS-1:0]             ch_done,
  output logic [NUM_CHANNELS-1:0]             ch_rvalid,
  output logic [DATA_WIDTH-1:0]               ch_rdata,
  output logic                                tx_re,
  output logic [ADDRESS_WIDTH-1:0]            tx_raddr,
  output logic [1:0]                          tx_rlength,
  input  logic                                tx_ralmostfull,
  input  logic                                rx_rvalid,
  input  logic [DATA_WIDTH-1:0]               rx_rdata,
  output logic                                err
);

  localparam int CH_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int OUT_W     = LOG2_MAX_OUTSTANDING + 1;
  localparam int TAG_DEPTH = 1 << LOG2_TAG_DEPTH;
  localparam int TAG_W     = CH_W + 3;   // {channel, burst size 1/2/4}
  localparam logic [OUT_W:0]          MAX_OUT  = {2'b01, {LOG2_MAX_OUTSTANDING{1'b0}}};
  localparam logic [LOG2_TAG_DEPTH:0] TAG_FULL = {1'b1, {LOG2_TAG_DEPTH{1'b0}}};

  // Per-channel state
  logic [NUM_CHANNELS-1:0]  busy_q, busy_d;
  logic [ADDRESS_WIDTH-1:0] addr_q [NUM_CHANNELS];
  logic [ADDRESS_WIDTH-1:0] addr_d [NUM_CHANNELS];
  logic [15:0]              remaining_q [NUM_CHANNELS];   // lines still to request
  logic [15:0]              remaining_d [NUM_CHANNELS];
  logic [15:0]              beats_left_q [NUM_CHANNELS];  // lines still to deliver
  logic [15:0]              beats_left_d [NUM_CHANNELS];
  logic [OUT_W-1:0]         outstanding_q [NUM_CHANNELS];
  logic [OUT_W-1:0]         outstanding_d [NUM_CHANNELS];

  // Registered outputs
  logic [NUM_CHANNELS-1:0]  done_q, done_d;
  logic [NUM_CHANNELS-1:0]  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     tx_re_q, tx_re_d;
  logic [ADDRESS_WIDTH-1:0] tx_raddr_q, tx_raddr_d;
  logic [1:0]               tx_rlength_q, tx_rlength_d;
  logic                     err_q, err_d;

  // Arbiter and tag FIFO
  logic [CH_W-1:0]             rr_next_q, rr_next_d;   // highest-priority channel
  logic [LOG2_TAG_DEPTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG2_TAG_DEPTH:0]     tag_count_q, tag_count_d;
  logic [1:0]                  beat_idx_q, beat_idx_d; // beat within head burst
  logic [TAG_W-1:0]            tag_mem_q [TAG_DEPTH];

  // Combinational helpers
  logic [2:0]              burst [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] eligible;
  logic                    grant_found;
  logic [CH_W-1:0]         grant_ch;
  int                      rr_idx;
  logic                    tag_push, tag_pop, tag_full;
  logic [TAG_W-1:0]        tag_wdata, tag_head;
  logic [CH_W-1:0]         head_ch;
  logic [2:0]              head_len;

  always_comb begin
    // Hold state by default; pulses default low.
    busy_d       = busy_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    beats_left_d = beats_left_q;
    outstanding_d = outstanding_q;
    done_d       = '0;
    rvalid_d     = '0;
    rdata_d      = rdata_q;
    tx_re_d      = 1'b0;
    tx_raddr_d   = tx_raddr_q;
    tx_rlength_d = tx_rlength_q;
    err_d        = err_q;
    rr_next_d    = rr_next_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tag_count_d  = tag_count_q;
    beat_idx_d   = beat_idx_q;
    tag_push     = 1'b0;
    tag_pop      = 1'b0;
    tag_wdata    = '0;
    grant_found  = 1'b0;
    grant_ch     = '0;
    rr_idx       = 0;
    tag_full     = (tag_count_q == TAG_FULL);
    tag_head     = tag_mem_q[rd_ptr_q];
    head_ch      = tag_head[TAG_W-1:3];
    head_len     = tag_head[2:0];

    // Burst sizing and eligibility per channel
    for (int c = 0; c < NUM_CHANNELS; c++) begin
`ifdef MULTI_CHANNEL_DMA_READ_BURST_EN
      if (addr_q[c][1:0] == 2'b00 && remaining_q[c] >= 16'd4)
        burst[c] = 3'd4;
      else if (addr_q[c][0] == 1'b0 && remaining_q[c] >= 16'd2)
        burst[c] = 3'd2;
      else
        burst[c] = 3'd1;
`else
      burst[c] = 3'd1;
`endif
      eligible[c] = busy_q[c] && (remaining_q[c] != 16'd0) && !ch_almostfull[c]
                    && !tx_ralmostfull && !tag_full
                    && (({1'b0, outstanding_q[c]} + {{(OUT_W-2){1'b0}}, burst[c]}) <= MAX_OUT);
    end

    // Round-robin: search starting at rr_next_q, first eligible wins
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rr_idx = (int'(rr_next_q) + i) % NUM_CHANNELS;
      if (!grant_found && eligible[rr_idx]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(rr_idx);
      end
    end

    // Issue
    if (grant_found) begin
      tx_re_d    = 1'b1;
      tx_raddr_d = addr_q[grant_ch];
      case (burst[grant_ch])
        3'd4:    tx_rlength_d = 2'b11;
        3'd2:    tx_rlength_d = 2'b01;
        default: tx_rlength_d = 2'b00;
      endcase
      addr_d[grant_ch]        = addr_q[grant_ch] + ADDRESS_WIDTH'(burst[grant_ch]);
      remaining_d[grant_ch]   = remaining_q[grant_ch] - 16'(burst[grant_ch]);
      outstanding_d[grant_ch] = outstanding_q[grant_ch] + OUT_W'(burst[grant_ch]);
      rr_next_d = CH_W'((int'(grant_ch) + 1) % NUM_CHANNELS);
      tag_push  = 1'b1;
      tag_wdata = {grant_ch, burst[grant_ch]};
    end

    // Receive: steer by head tag. Subtracting from the _d value (not _q)
    // lets an issue and a beat on the same channel net out.
    if (rx_rvalid) begin
      if (tag_count_q == '0) begin
        err_d = 1'b1;
      end else begin
        rvalid_d[head_ch]      = 1'b1;
        rdata_d                = rx_rdata;
        outstanding_d[head_ch] = outstanding_d[head_ch] - OUT_W'(1);
        beats_left_d[head_ch]  = beats_left_q[head_ch] - 16'd1;
        if ((3'(beat_idx_q) + 3'd1) == head_len) begin
          tag_pop    = 1'b1;
          beat_idx_d = 2'd0;
          rd_ptr_d   = rd_ptr_q + LOG2_TAG_DEPTH'(1);
        end else begin
          beat_idx_d = beat_idx_q + 2'd1;
        end
      end
    end

    if (tag_push) wr_ptr_d = wr_ptr_q + LOG2_TAG_DEPTH'(1);
    if (tag_push && !tag_pop)
      tag_count_d = tag_count_q + (LOG2_TAG_DEPTH+1)'(1);
    else if (!tag_push && tag_pop)
      tag_count_d = tag_count_q - (LOG2_TAG_DEPTH+1)'(1);

    // Completion and start. Completion fires the cycle after the last beat
    // was presented on ch_rvalid; start is only looked at when idle.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (busy_q[c]) begin
        if (rvalid_q[c] && beats_left_q[c] == 16'd0) begin
          done_d[c] = 1'b1;
          busy_d[c] = 1'b0;
        end
      end else if (ch_start[c]) begin
        if (ch_lines[c*16 +: 16] == 16'd0) begin
          done_d[c] = 1'b1;
        end else begin
          busy_d[c]       = 1'b1;
          addr_d[c]       = ch_addr[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          remaining_d[c]  = ch_lines[c*16 +: 16];
          beats_left_d[c] = ch_lines[c*16 +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q       <= '0;
      done_q       <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      tx_re_q      <= 1'b0;
      tx_raddr_q   <= '0;
      tx_rlength_q <= '0;
      err_q        <= 1'b0;
      rr_next_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_count_q  <= '0;
      beat_idx_q   <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        addr_q[c]        <= '0;
        remaining_q[c]   <= '0;
        beats_left_q[c]  <= '0;
        outstanding_q[c] <= '0;
      end
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      tx_re_q      <= tx_re_d;
      tx_raddr_q   <= tx_raddr_d;
      tx_rlength_q <= tx_rlength_d;
      err_q        <= err_d;
      rr_next_q    <= rr_next_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_count_q  <= tag_count_d;
      beat_idx_q   <= beat_idx_d;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        addr_q[c]        <= addr_d[c];
        remaining_q[c]   <= remaining_d[c];
        beats_left_q[c]  <= beats_left_d[c];
        outstanding_q[c] <= outstanding_d[c];
      end
    end
  end

  // Tag storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem_q[wr_ptr_q] <= tag_wdata;
  end

  assign ch_busy    = busy_q;
  assign ch_done    = done_q;
  assign ch_rvalid  = rvalid_q;
  assign ch_rdata   = rdata_q;
  assign tx_re      = tx_re_q;
  assign tx_raddr   = tx_raddr_q;
  assign tx_rlength = tx_rlength_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_dma_read.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multi_channel_dma_read                                     |
// | Purpose  : Scoreboard bench for multi_channel_dma_read. A memory model   |
// |            answers requests. Expected requests and data are queued as   |
// |            stimulus is issued and a monitor pops and compares them.     |
// |            Channel 0 uses addresses below 0x1000, channel 1 uses        |
// |            0x1000..0x1FFF, so tx_raddr[12] identifies the requester.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_multi_channel_dma_read;
  localparam int NC = 2;
  localparam int DW = 64;
  localparam int AW = 42;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic [NC-1:0]     ch_start, ch_almostfull, ch_busy, ch_done, ch_rvalid;
  logic [NC*AW-1:0]  ch_addr;
  logic [NC*16-1:0]  ch_lines;
  logic [DW-1:0]     ch_rdata, rx_rdata;
  logic              tx_re, tx_ralmostfull, rx_rvalid, err;
  logic [AW-1:0]     tx_raddr;
  logic [1:0]        tx_rlength;

  multi_channel_dma_read #(
    .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .LOG2_MAX_OUTSTANDING(6), .LOG2_TAG_DEPTH(6)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ch_start(ch_start), .ch_addr(ch_addr), .ch_lines(ch_lines),
    .ch_almostfull(ch_almostfull),
    .ch_busy(ch_busy), .ch_done(ch_done), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
    .tx_re(tx_re), .tx_raddr(tx_raddr), .tx_rlength(tx_rlength),
    .tx_ralmostfull(tx_ralmostfull),
    .rx_rvalid(rx_rvalid), .rx_rdata(rx_rdata), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=0x%0h expected=nothing", name, act);
  endtask

  // Line content returned by the memory model
  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return 64'hC0DE_0000_0000_0000 ^ {22'd0, a};
  endfunction

  // Scoreboard queues: requests are {rlength, addr}
  logic [AW+1:0] exp_req0[$], exp_req1[$];
  logic [DW-1:0] exp_dat0[$], exp_dat1[$];
  int            grant_log[$];
  int            done_cnt0 = 0, done_cnt1 = 0;
  int            beat_cnt0 = 0, beat_cnt1 = 0;

  task automatic exp_reqs(input int ch, input logic [AW-1:0] a, input int n,
                          input int step, input logic [1:0] len);
    logic [AW-1:0] x;
    x = a;
    for (int k = 0; k < n; k++) begin
      if (ch == 0) exp_req0.push_back({len, x});
      else         exp_req1.push_back({len, x});
      x = x + AW'(step);
    end
  endtask

  task automatic exp_data(input int ch, input logic [AW-1:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      if (ch == 0) exp_dat0.push_back(dat(a + AW'(k)));
      else         exp_dat1.push_back(dat(a + AW'(k)));
    end
  endtask

  // Memory model: answers requests in order, one beat per cycle
  logic [AW+1:0] resp_q[$];
  logic          resp_hold = 1'b0;
  logic [AW-1:0] r_addr;
  int            r_left = 0;
  logic [AW+1:0] r_ent;

  initial begin
    rx_rvalid = 1'b0;
    rx_rdata  = '0;
    forever begin
      @(negedge clk);
      if (tx_re === 1'b1) resp_q.push_back({tx_rlength, tx_raddr});
      rx_rvalid = 1'b0;
      if (!resp_hold && (r_left > 0 || resp_q.size() > 0)) begin
        if (r_left == 0) begin
          r_ent  = resp_q.pop_front();
          r_addr = r_ent[AW-1:0];
          r_left = (r_ent[AW+1:AW] == 2'b11) ? 4 : (r_ent[AW+1:AW] == 2'b01) ? 2 : 1;
        end
        rx_rvalid = 1'b1;
        rx_rdata  = dat(r_addr);
        r_addr    = r_addr + AW'(1);
        r_left--;
      end
    end
  end

  // Monitor
  int            m_ch;
  logic [AW+1:0] m_req;
  logic [DW-1:0] m_dat;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_re === 1'b1) begin
        m_ch = int'(tx_raddr[12]);
        grant_log.push_back(m_ch);
        if ((m_ch == 0 && exp_req0.size() == 0) || (m_ch == 1 && exp_req1.size() == 0)) begin
          fail_unexpected("unexpected_request", {20'd0, tx_rlength, tx_raddr});
        end else begin
          m_req = (m_ch == 0) ? exp_req0.pop_front() : exp_req1.pop_front();
          check("request_addr_len", {20'd0, tx_rlength, tx_raddr}, {20'd0, m_req});
        end
      end
      if (ch_rvalid !== '0) check("rvalid_onehot", 64'($onehot(ch_rvalid)), 64'd1);
      for (int c = 0; c < NC; c++) begin
        if (ch_rvalid[c] === 1'b1) begin
          if (c == 0) beat_cnt0++; else beat_cnt1++;
          if ((c == 0 && exp_dat0.size() == 0) || (c == 1 && exp_dat1.size() == 0)) begin
            fail_unexpected("unexpected_rvalid", ch_rdata);
          end else begin
            m_dat = (c == 0) ? exp_dat0.pop_front() : exp_dat1.pop_front();
            check("rdata", ch_rdata, m_dat);
          end
        end
        if (ch_done[c] === 1'b1) begin
          if (c == 0) begin
            done_cnt0++;
            check("done0_beats_left", 64'(exp_dat0.size()), 64'd0);
          end else begin
            done_cnt1++;
            check("done1_beats_left", 64'(exp_dat1.size()), 64'd0);
          end
        end
      end
    end
  end

  task automatic wait_done(input int ch, input int target, input string name);
    for (int i = 0; i < 2000; i++) begin
      if (((ch == 0) ? done_cnt0 : done_cnt1) >= target) break;
      @(negedge clk);
    end
    check(name, 64'((ch == 0) ? done_cnt0 : done_cnt1), 64'(target));
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] a, input int n);
    ch_start[ch]          = 1'b1;
    ch_addr[ch*AW +: AW]  = a;
    ch_lines[ch*16 +: 16] = 16'(n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int b0;

  initial begin
    resetn = 1'b0; ch_start = '0; ch_addr = '0; ch_lines = '0;
    ch_almostfull = '0; tx_ralmostfull = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset_tx_re", tx_re, 0);
    check("reset_tx_raddr", tx_raddr, 0);
    check("reset_tx_rlength", tx_rlength, 0);
    check("reset_busy", ch_busy, 0);
    check("reset_done", ch_done, 0);
    check("reset_rvalid", ch_rvalid, 0);
    check("reset_rdata", ch_rdata, 0);
    check("reset_err", err, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Both channels start together, 4 lines each: ch0 granted first, alternating
    grant_log.delete();
`ifdef MULTI_CHANNEL_DMA_READ_BURST_EN
    exp_reqs(0, 42'h400, 1, 4, 2'b11);
    exp_reqs(1, 42'h1400, 1, 4, 2'b11);
`else
    exp_reqs(0, 42'h400, 4, 1, 2'b00);
    exp_reqs(1, 42'h1400, 4, 1, 2'b00);
`endif
    exp_data(0, 42'h400, 4);
    exp_data(1, 42'h1400, 4);
    set_ch(0, 42'h400, 4);
    set_ch(1, 42'h1400, 4);
    @(negedge clk);
    ch_start = '0;
    check("dual_busy", ch_busy, 2'b11);
    wait_done(0, 1, "dual_done0");
    wait_done(1, 1, "dual_done1");
`ifdef MULTI_CHANNEL_DMA_READ_BURST_EN
    check("dual_grant_count", 64'(grant_log.size()), 64'd2);
`else
    check("dual_grant_count", 64'(grant_log.size()), 64'd8);
`endif
    for (int i = 0; i < grant_log.size(); i++)
      check("dual_grant_order", 64'(grant_log[i]), 64'(i % 2));

    // Aligned 8 lines at 0x100
`ifdef MULTI_CHANNEL_DMA_READ_BURST_EN
    exp_req0.push_back({2'b11, 42'h100});
    exp_req0.push_back({2'b11, 42'h104});
`else
    exp_reqs(0, 42'h100, 8, 1, 2'b00);
`endif
    exp_data(0, 42'h100, 8);
    b0 = beat_cnt0;
    set_ch(0, 42'h100, 8);
    @(negedge clk);
    ch_start = '0;
    check("aligned_busy", ch_busy[0], 1);
    wait_done(0, 2, "aligned_done");
    check("aligned_beats", 64'(beat_cnt0 - b0), 64'd8);

    // Unaligned 5 lines at 0x101
`ifdef MULTI_CHANNEL_DMA_READ_BURST_EN
    exp_req0.push_back({2'b00, 42'h101});
    exp_req0.push_back({2'b01, 42'h102});
    exp_req0.push_back({2'b01, 42'h104});
`else
    exp_reqs(0, 42'h101, 5, 1, 2'b00);
`endif
    exp_data(0, 42'h101, 5);
    set_ch(0, 42'h101, 5);
    @(negedge clk);
    ch_start = '0;
    wait_done(0, 3, "unaligned_done");

    // Zero lines: immediate done pulse, never busy
    set_ch(0, 42'h300, 0);
    @(negedge clk);
    ch_start = '0;
    check("zero_done_pulse", ch_done[0], 1);
    check("zero_not_busy", ch_busy[0], 0);
    @(negedge clk);
    check("zero_done_single", ch_done[0], 0);
    check("zero_done_count", 64'(done_cnt0), 64'd4);

    // Start while busy is ignored
`ifdef MULTI_CHANNEL_DMA_READ_BURST_EN
    exp_reqs(1, 42'h1500, 1, 4, 2'b11);
`else
    exp_reqs(1, 42'h1500, 4, 1, 2'b00);
`endif
    exp_data(1, 42'h1500, 4);
    set_ch(1, 42'h1500, 4);
    @(negedge clk);
    ch_start = '0;
    check("busy_after_start", ch_busy[1], 1);
    set_ch(1, 42'h1600, 2);
    @(negedge clk);
    ch_start = '0;
    wait_done(1, 2, "busy_start_done");
    repeat (6) @(negedge clk);
    check("busy_start_done_count", 64'(done_cnt1), 64'd2);
    check("busy_start_idle", ch_busy[1], 0);

    // tx_ralmostfull stall window mid-transfer
`ifdef MULTI_CHANNEL_DMA_READ_BURST_EN
    exp_reqs(0, 42'h200, 8, 4, 2'b11);
`else
    exp_reqs(0, 42'h200, 32, 1, 2'b00);
`endif
    exp_data(0, 42'h200, 32);
    b0 = beat_cnt0;
    set_ch(0, 42'h200, 32);
    @(negedge clk);
    ch_start = '0;
    repeat (4) @(negedge clk);
    tx_ralmostfull = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("txre_during_almostfull", tx_re, 0);
    end
    tx_ralmostfull = 1'b0;
    wait_done(0, 5, "almostfull_done");
    check("almostfull_beats", 64'(beat_cnt0 - b0), 64'd32);

    // Reset with 4 lines outstanding: late responses are orphans
    resp_hold = 1'b1;
`ifdef MULTI_CHANNEL_DMA_READ_BURST_EN
    exp_reqs(0, 42'h40, 1, 4, 2'b11);
`else
    exp_reqs(0, 42'h40, 4, 1, 2'b00);
`endif
    exp_data(0, 42'h40, 4);
    set_ch(0, 42'h40, 4);
    @(negedge clk);
    ch_start = '0;
    for (int i = 0; i < 50; i++) begin
      if (exp_req0.size() == 0) break;
      @(negedge clk);
    end
    check("orphan_reqs_issued", 64'(exp_req0.size()), 64'd0);
    check("orphan_err_before", err, 0);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("orphan_reset_busy", ch_busy, 0);
    check("orphan_reset_tx_re", tx_re, 0);
    exp_dat0.delete();
    b0 = beat_cnt0;
    resetn = 1'b1;
    resp_hold = 1'b0;
    repeat (12) @(negedge clk);
    check("orphan_err_set", err, 1);
    check("orphan_no_rvalid", 64'(beat_cnt0 - b0), 64'd0);
    check("orphan_idle", ch_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
